// File: rtl/bitop_pkg.sv
// Shared types and the operator evaluation function for the bit-operation engine.
package bitop_pkg;

    // Widest operand the evaluation function handles; both operand widths must not exceed it.
    localparam int MAX_W = 32;

    typedef enum logic [2:0] {
        OP_NOT  = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_XOR  = 3'd3,
        OP_XNOR = 3'd4,
        OP_LNOT = 3'd5,
        OP_LAND = 3'd6,
        OP_LOR  = 3'd7
    } opCode_t;

    // One result together with the operator that produced it.
    typedef struct packed {
        opCode_t          op;
        logic [MAX_W-1:0] res;
    } resRec_t;

    // Pure operator evaluation. Callers zero-extend both operands to MAX_W and
    // keep only the low A_W bits of the return value, which implements the
    // zero-extend-then-truncate width rule for every operator.
    function automatic logic [MAX_W-1:0] evalOp(input opCode_t op,
                                               input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b);
        logic [MAX_W-1:0] r;
        r = '0;
        case (op)
            OP_NOT:  r = ~a;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            OP_LNOT: r = {{(MAX_W-1){1'b0}}, (a == '0)};
            OP_LAND: r = {{(MAX_W-1){1'b0}}, ((a != '0) && (b != '0))};
            OP_LOR:  r = {{(MAX_W-1){1'b0}}, ((a != '0) || (b != '0))};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bitop_if.sv
// Operand and result handshake bundle of the bit-operation engine.
//
// Handshake: a beat moves across a channel on every rising clk edge where
// valid and ready are both 1. A producer that raises valid keeps it high, with
// its payload stable, until that transfer edge. ready may depend
// combinationally on the opposite side's ready (in_ready follows out_ready),
// but never on the same channel's valid.
interface bitop_if #(
    parameter int A_W = 4,
    parameter int B_W = 5
) ();

    logic           in_valid;
    logic           in_ready;
    logic [A_W-1:0] in_a;
    logic [B_W-1:0] in_b;
    logic [2:0]     in_op;

    logic           out_valid;
    logic           out_ready;
    logic [A_W-1:0] out_res;
    logic [2:0]     out_op;

    logic [7:0]     op_count;

    // Environment side: drives operands and accepts results.
    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_res, out_op, op_count
    );

    // Engine side.
    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_res, out_op, op_count
    );

endinterface

// File: rtl/bitop_fifo.sv
// Output queue of the engine: a power-of-two deep FIFO with a combinational
// read port. Push and pop on the same edge are allowed even when full.
module bitop_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign popData = mem[rdPtr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Guard against the parent pushing into a full queue or popping an empty one.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && full && !pop))
                else $error("bitop_fifo: push into full queue without pop");
            assert (!(pop && empty))
                else $error("bitop_fifo: pop from empty queue");
        end
    end

endmodule

// File: rtl/bitop_engine.sv
// Bit-operation engine: evaluates one operator per accepted beat into the S1
// stage register, then queues results in an output FIFO released in order.
module bitop_engine
    import bitop_pkg::*;
#(
    parameter int A_W        = 4,
    parameter int B_W        = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    bitop_if.slave bus
);

    // FIFO word: operator code above the A_W-bit result.
    localparam int FW = A_W + 3;

    logic           s1Valid;
    logic [A_W-1:0] s1Res;
    opCode_t        s1Op;

    logic           fifoFull;
    logic           fifoEmpty;
    logic           push;
    logic           pop;
    logic           accept;
    logic [FW-1:0]  fifoRd;
    logic [7:0]     opCount;

    // A result leaves whenever the queue holds one and the consumer is ready.
    assign pop    = !fifoEmpty && bus.out_ready;
    // S1 drains into the queue when there is room, counting a slot freed by a same-edge pop.
    assign push   = s1Valid && (!fifoFull || pop);
    // Ready when S1 is free or emptying this edge; forced low while reset is applied.
    assign bus.in_ready = rst_n && (!s1Valid || push);
    assign accept = bus.in_valid && bus.in_ready;

    // S1 stage: load the evaluated result on accept, clear once it moved to the queue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1Valid <= 1'b0;
            s1Res   <= '0;
            s1Op    <= OP_NOT;
        end else if (accept) begin
            s1Valid <= 1'b1;
            s1Res   <= A_W'(evalOp(opCode_t'(bus.in_op), MAX_W'(bus.in_a), MAX_W'(bus.in_b)));
            s1Op    <= opCode_t'(bus.in_op);
        end else if (push) begin
            s1Valid <= 1'b0;
        end
    end

    bitop_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pushData ({s1Op, s1Res}),
        .pop      (pop),
        .popData  (fifoRd),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    // Completed output transfers, wrapping modulo 256.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opCount <= '0;
        end else if (pop) begin
            opCount <= opCount + 8'd1;
        end
    end

    // Result outputs read as zero whenever nothing is being offered.
    assign bus.out_valid = !fifoEmpty;
    assign bus.out_res   = fifoEmpty ? '0 : fifoRd[A_W-1:0];
    assign bus.out_op    = fifoEmpty ? 3'b000 : fifoRd[FW-1:A_W];
    assign bus.op_count  = opCount;

endmodule

// File: doc/bitop_engine.md
BITOP_ENGINE -- requirements
Module: bitop_engine

Interface
REQ-001 Parameter A_W, default 4: width of operand A.
REQ-002 Parameter B_W, default 5: width of operand B.
REQ-003 Parameter FIFO_DEPTH, default 2: number of output FIFO entries; power of two, at least 2.
REQ-004 Port clk, input, 1: single clock; all state SHALL update on rising edge.
REQ-005 Port rst_n, input, 1: synchronous active-low reset, sampled on the rising edge of clk.
REQ-006 Port in_valid, input, 1: the operand beat is valid.
REQ-007 Port in_ready, output, 1: the engine accepts the beat this cycle.
REQ-008 Port in_a, input, A_W: operand A.
REQ-009 Port in_b, input, B_W: operand B.
REQ-010 Port in_op, input, 3: operator code (values in REQ-014).
REQ-011 Port out_valid / out_ready, output / input, 1 each: result handshake.
REQ-012 Port out_res, output, A_W: result. Port out_op, output, 3: operator code echoed with the result.
REQ-013 Port op_count, output, 8: number of completed output transfers.

Function
REQ-014 Operator codes: 0 NOT, 1 AND, 2 OR, 3 XOR, 4 XNOR, 5 LNOT, 6 LAND, 7 LOR; all 8 codes are legal.
REQ-015 Width rule: in_a SHALL be zero-extended to max(A_W,B_W) bits; the bitwise result SHALL be truncated to its low A_W bits.
REQ-016 NOT: result = ~in_a; in_b is ignored.
REQ-017 LNOT / LAND / LOR: result bit 0 = (in_a==0) / (in_a!=0 && in_b!=0) / (in_a!=0 || in_b!=0); upper bits SHALL be 0.
REQ-018 Transfer rule: a transfer occurs on any edge where valid and ready are both 1.
REQ-019 Valid rule: once asserted, out_valid SHALL remain asserted with out_res/out_op stable until the transfer completes.
REQ-020 Pipeline: stage register S1 (result and op) SHALL be followed by the output FIFO.
REQ-021 An accepted beat SHALL load S1 on the accept edge.
REQ-022 S1 SHALL move into the FIFO on the next edge on which the FIFO is not full, or is full with a pop on the same edge.
REQ-023 Minimum latency: out_valid SHALL rise 2 cycles after the accept edge.
REQ-024 in_ready = !S1_valid || S1 drains this edge. Sustained throughput SHALL be 1 beat per cycle while out_ready is held at 1.
REQ-025 FIFO full with out_ready=0: S1 SHALL hold and in_ready SHALL be 0. No beat SHALL be lost or duplicated.
REQ-026 FIFO empty: out_valid SHALL be 0. A simultaneous FIFO push and pop SHALL leave the occupancy unchanged and preserve order.
REQ-027 Results SHALL leave the engine in acceptance order.
REQ-028 op_count SHALL increment on each output transfer and wrap from 255 to 0.

Reset
REQ-029 While rst_n=0 at an edge, the engine SHALL clear S1, the FIFO pointers and occupancy, and op_count.
REQ-030 Outputs after reset: out_valid=0, in_ready=1, out_res=0, out_op=0, op_count=0.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight beats with no partial output.
REQ-032 in_ready SHALL be 0 during any cycle in which rst_n=0.

Structure
REQ-033 Package bitop_pkg SHALL hold the operator enum (3-bit) and the result/op record type.
REQ-034 The output queue SHALL be the sub-module bitop_fifo (parameterised on width and depth, same clk/rst_n).
REQ-035 Operator evaluation SHALL be a pure function in bitop_pkg, used by the S1 load logic.

Verification
REQ-036 a=4, b=3, out_ready=1, ops 1..4 back-to-back -> out_res = 0000, 0111, 0111, 1000 in order; op_count=4.
REQ-037 a=4, b=4, AND; then NOT -> 0100, then 1011; out_valid rises exactly 2 cycles after each accept edge.
REQ-038 a=0, b=5, ops LNOT / LAND / LOR -> 0001 / 0000 / 0001.
REQ-039 out_ready=0 with 4 beats offered -> exactly 3 accepted (S1 plus 2 FIFO entries), after which in_ready=0. Releasing out_ready -> all results delivered in order, with no gap at 1 beat per cycle.
REQ-040 rst_n=0 for one edge while the FIFO holds 2 entries -> next cycle out_valid=0, op_count=0, in_ready=1; no stale result appears later.
REQ-041 256 transfers -> op_count wraps to 0.
